fifo_prog: RTL

FIFO_PROG -- requirements
Module: fifo_prog

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_prog.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the fifo family.
// Latency: n/a (package). Backpressure: n/a.
// Contents: ptr_w() = pointer width including wrap bit, idx_w() = storage index width.
package fifo_pkg;

   // Pointer width: index bits plus one wrap bit, so full and empty stay distinguishable.
   function automatic int ptr_w(input int rows);
      return $clog2(rows) + 1;
   endfunction

   // Index width used to address storage rows.
   function automatic int idx_w(input int rows);
      return $clog2(rows);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the fifo family: one write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data is combinational from raddr.
// Backpressure: none; the caller qualifies we. No reset: pointers alone define validity.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (async read port).
module fifo_mem #(
   parameter int  ROWS   = 8,
   parameter type DATA_T = logic [7:0],
   parameter int  AW     = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  DATA_T         wdata,
   input  logic [AW-1:0] raddr,
   output DATA_T         rdata
);

   DATA_T mem [ROWS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost flags, sticky over/underflow and selectable read mode.
// Latency: FWFT=0 -> r_data one cycle after accepted read; FWFT=1 -> head visible the cycle after its write.
// Backpressure: w_stall = full, r_stall = empty, both purely from current state; refused requests set sticky flags.
// Ports: clk, reset (async, active-high), flush (sync clear); w_req/w_data/w_stall write side;
//        r_req/r_data/r_valid/r_stall read side; write_ptr/read_ptr/count status; almost_full/almost_empty,
//        overflow/underflow flags.
module fifo_prog
   import fifo_pkg::*;
#(
   parameter int  ROWS      = 8,
   parameter type DATA_T    = logic [7:0],
   parameter bit  FWFT      = 1'b0,
   parameter int  AF_THRESH = ROWS - 2,
   parameter int  AE_THRESH = 2,
   localparam int PW        = ptr_w(ROWS),
   localparam int IW        = idx_w(ROWS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          w_req,
   input  DATA_T         w_data,
   output logic          w_stall,
   input  logic          r_req,
   output DATA_T         r_data,
   output logic          r_valid,
   output logic          r_stall,
   output logic [PW-1:0] write_ptr,
   output logic [PW-1:0] read_ptr,
   output logic [PW-1:0] count,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow,
   output logic          underflow
);

   logic [PW-1:0] wp_q, rp_q;
   logic [PW-1:0] wp_n, rp_n, count_n;
   logic          full, empty;
   logic          w_acc, r_acc;
   logic          af_q, ae_q, ov_q, un_q;
   DATA_T         mem_rdata;

   // Wrap bit disambiguates full from empty when the index bits match.
   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[IW-1:0] == rp_q[IW-1:0]) && (wp_q[PW-1] != rp_q[PW-1]);

   assign w_stall = full;
   assign r_stall = empty;

   // Flush swallows both requests in its cycle. At full only the read can win, at empty only the write.
   assign w_acc = w_req & ~full  & ~flush;
   assign r_acc = r_req & ~empty & ~flush;

   assign wp_n    = flush ? '0 : wp_q + PW'(w_acc);
   assign rp_n    = flush ? '0 : rp_q + PW'(r_acc);
   assign count_n = wp_n - rp_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
         af_q <= 1'b0;
         ae_q <= 1'b1;
         ov_q <= 1'b0;
         un_q <= 1'b0;
      end else begin
         wp_q <= wp_n;
         rp_q <= rp_n;
         // Flags follow the next occupancy so they change on the same edge as count.
         af_q <= (int'(count_n) >= AF_THRESH);
         ae_q <= (int'(count_n) <= AE_THRESH);
         if (flush) begin
            ov_q <= 1'b0;
            un_q <= 1'b0;
         end else begin
            ov_q <= ov_q | (w_req & full);
            un_q <= un_q | (r_req & empty);
         end
      end
   end

   assign write_ptr    = wp_q;
   assign read_ptr     = rp_q;
   assign count        = wp_q - rp_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign overflow     = ov_q;
   assign underflow    = un_q;

   fifo_mem #(
      .ROWS   (ROWS),
      .DATA_T (DATA_T),
      .AW     (IW)
   ) u_mem (
      .clk   (clk),
      .we    (w_acc),
      .waddr (wp_q[IW-1:0]),
      .wdata (w_data),
      .raddr (rp_q[IW-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT) begin : g_fwft
         // Head of queue is always presented; r_req simply pops it.
         assign r_data  = mem_rdata;
         assign r_valid = ~empty;
      end else begin : g_reg
         DATA_T rd_q;
         logic  rv_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rd_q <= '0;
               rv_q <= 1'b0;
            end else begin
               rv_q <= r_acc;
               // r_data holds between reads; flush only drops the valid.
               if (r_acc) begin
                  rd_q <= mem_rdata;
               end
            end
         end

         assign r_data  = rd_q;
         assign r_valid = rv_q;
      end
   endgenerate

endmodule
